// File: rtl/mem_access_pkg.sv
// Shared constants, state encoding and size/alignment helpers for the memory access sequencer.
package mem_access_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam int MEM_LAT_DEFAULT = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_FIN  = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    // The reserved size code behaves exactly like a word access.
    function automatic logic is_word_size(input logic [1:0] size);
        return !(size == SIZE_HALF || size == SIZE_BYTE);
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_HALF: return !lo[0];
            SIZE_BYTE: return 1'b1;
            default:   return (lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_shifter.sv
// Little-endian lane extract (load, zero-extended) and lane insert (store merge) on a 32-bit word.
module mem_lane_shifter
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    output logic [31:0] extract_o,
    output logic [31:0] insert_o
);

    always_comb begin
        extract_o = '0;
        insert_o  = word_i;
        case (size_i)
            SIZE_HALF: begin
                extract_o[15:0] = word_i[{lane_i[1], 4'b0000} +: 16];
                insert_o[{lane_i[1], 4'b0000} +: 16] = data_i[15:0];
            end
            SIZE_BYTE: begin
                extract_o[7:0] = word_i[{lane_i, 3'b000} +: 8];
                insert_o[{lane_i, 3'b000} +: 8] = data_i[7:0];
            end
            default: begin
                extract_o = word_i;
                insert_o  = data_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Sequences word/half/byte loads and stores onto a word-wide memory; sub-word stores
// read the old word, merge the new lane(s) and write it back. Misaligned requests only pulse misalign.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              misalign,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] wword_q, wword_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] lane_extract, lane_insert;

    mem_lane_shifter u_shifter (
        .word_i    (mem_rdata),
        .data_i    (wdata_q),
        .lane_i    (addr_q[1:0]),
        .size_i    (size_q),
        .extract_o (lane_extract),
        .insert_o  (lane_insert)
    );

    // Valid/ready contract: req is only looked at while busy is low; an accepted
    // access always ends in exactly one done or misalign pulse, after which busy drops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        wword_d = wword_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    wr_d    = wr;
                    size_d  = size;
                    wdata_d = wdata;
                    wword_d = wdata;
                    cnt_d   = '0;
                    if (!is_aligned(size, addr[1:0]))
                        state_d = ST_ERR;
                    else if (wr && is_word_size(size))
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (cnt_q == CNT_LAST) begin
                    if (wr_q) begin
                        wword_d = lane_insert;
                        state_d = ST_WR;
                    end else begin
                        rdata_d = lane_extract;
                        state_d = ST_FIN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WR:   state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= SIZE_WORD;
            wdata_q <= '0;
            wword_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            wword_q <= wword_d;
            rdata_q <= rdata_d;
        end
    end

    // All handshake and memory-side outputs decode from the state, so reset clears them at once.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FIN);
        misalign  = (state_q == ST_ERR);
        mem_wr    = (state_q == ST_WR);
        mem_wdata = (state_q == ST_WR) ? wword_q : '0;
        mem_addr  = (state_q == ST_RD || state_q == ST_WR) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        rdata     = rdata_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a behavioural memory/lane model.
module tb_mem_access_unit;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [2:0]  dbg_state;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic [31:0] exp_q [$];
    logic [31:0] model_rdata;
    int          checks;
    int          failures;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .misalign  (misalign),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / memory ----------------
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_init(input int i);
        case (i)
            4:       return 32'hDEADBEEF;
            8, 63:   return 32'h11223344;
            default: return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
        endcase
    endfunction

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= mem_init(i);
        end else if (mem_wr) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a, input logic [1:0] sz);
        if (sz == 2'b10) return (w >> (8 * a)) & 32'hFF;
        if (sz == 2'b01) return (w >> (8 * (a & 2'b10))) & 32'hFFFF;
        return w;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] d,
                                                input logic [1:0] a, input logic [1:0] sz);
        logic [31:0] mask;
        int sh;
        if (sz == 2'b10) begin
            sh = 8 * a;
            mask = 32'hFF << sh;
        end else if (sz == 2'b01) begin
            sh = 8 * (a & 2'b10);
            mask = 32'hFFFF << sh;
        end else begin
            return d;
        end
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    task automatic init_ref();
        for (int i = 0; i < 64; i++) ref_mem[i] = mem_init(i);
        model_rdata = 32'h0;
        exp_q.delete();
    endtask

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h state=%0d t=%0t", tag, got, exp, dbg_state, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_access(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic        aligned, word_sz;
        logic [31:0] old, exp_word;
        int          exp_lat, exp_wr_at, end_k, wr_cnt, wr_cyc;
        word_sz  = !(sz == 2'b01 || sz == 2'b10);
        aligned  = (sz == 2'b10) || (sz == 2'b01 && !a[0]) || (word_sz && a[1:0] == 2'b00);
        old      = ref_mem[a[7:2]];
        exp_word = model_store(old, d, a[1:0], sz);
        exp_wr_at = 0;
        if (!aligned) begin
            exp_lat = 1;
        end else if (!w) begin
            exp_lat = 1 + LAT;
            exp_q.push_back(model_load(old, a[1:0], sz));
        end else if (word_sz) begin
            exp_lat = 2;
            exp_wr_at = 1;
        end else begin
            exp_lat = 2 + LAT;
            exp_wr_at = 1 + LAT;
        end

        req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
        @(posedge clk);
        end_k = 0; wr_cnt = 0; wr_cyc = 0;
        for (int k = 1; k <= 20 && end_k == 0; k++) begin
            @(negedge clk);
            // inputs scrambled while busy must have no effect
            req = 1'($urandom_range(0, 1)); wr = 1'($urandom); size = 2'($urandom);
            addr = $urandom; wdata = $urandom;
            if (k < exp_lat) check("mem_addr_busy", mem_addr, {a[31:2], 2'b00});
            if (mem_wr) begin
                wr_cnt++;
                wr_cyc = k;
                check("mem_wdata", mem_wdata, exp_word);
            end
            if (done || misalign) end_k = k;
        end
        req = 1'b0;
        check("end_cycle", end_k, exp_lat);
        check("misalign", misalign, !aligned);
        check("done", done, aligned);
        check("wr_count", wr_cnt, (exp_wr_at != 0) ? 1 : 0);
        check("wr_cycle", wr_cyc, exp_wr_at);
        if (aligned && !w && exp_q.size() > 0) model_rdata = exp_q.pop_front();
        if (aligned && w) ref_mem[a[7:2]] = exp_word;
        check("rdata", rdata, model_rdata);
        @(negedge clk);
        check("busy_after", busy, 1'b0);
    endtask

    task automatic held_req_test();
        int first, second, idle_b;
        first = 0; second = 0; idle_b = 1;
        req = 1'b1; wr = 1'b0; size = 2'b00; addr = 32'h10; wdata = 32'h0;
        @(posedge clk);
        for (int k = 1; k <= 40 && second == 0; k++) begin
            @(negedge clk);
            if (first != 0 && k == first + 1) idle_b = busy;
            if (done) begin
                if (first == 0) first = k;
                else second = k;
            end
        end
        req = 1'b0;
        check("held_first_done", first, 1 + LAT);
        check("held_idle_gap", idle_b, 0);
        check("held_second_done", second, 2 * LAT + 3);
        model_rdata = ref_mem[4];
        check("held_rdata", rdata, model_rdata);
        @(negedge clk);
    endtask

    task automatic reset_mid_op_test();
        int bad;
        req = 1'b1; wr = 1'b1; size = 2'b10; addr = 32'h35; wdata = 32'h000000A5;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("rst_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_misalign", misalign, 1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        init_ref();
        bad = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (mem_wr || done || busy) bad++;
        end
        check("rst_no_activity", bad, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks = 0; failures = 0;
        req = 1'b0; wr = 1'b0; size = 2'b00; addr = 32'h0; wdata = 32'h0;
        reset = 1'b1;
        init_ref();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_misalign", misalign, 1'b0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wr", mem_wr, 1'b0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_access(1'b0, 2'b00, 32'h0000_0010, 32'h0);
        check("word_load_value", model_rdata, 32'hDEADBEEF);
        run_access(1'b0, 2'b10, 32'h0000_00FD, 32'h0);
        check("vec253_value", model_rdata, 32'h0000_0033);
        run_access(1'b0, 2'b10, 32'h0000_00FE, 32'h0);
        run_access(1'b0, 2'b10, 32'h0000_00FF, 32'h0);
        check("vec255_value", model_rdata, 32'h0000_0011);
        run_access(1'b1, 2'b01, 32'h0000_0022, 32'h0000_ABCD);
        check("half_store_value", ref_mem[8], 32'hABCD_3344);
        run_access(1'b0, 2'b01, 32'h0000_0022, 32'h0);
        run_access(1'b0, 2'b00, 32'h0000_0006, 32'h0);
        run_access(1'b1, 2'b01, 32'h0000_0011, 32'h1234_5678);
        run_access(1'b1, 2'b11, 32'h0000_0040, 32'hCAFE_F00D);
        run_access(1'b0, 2'b11, 32'h0000_0040, 32'h0);
        held_req_test();
        reset_mid_op_test();

        for (int n = 0; n < 40; n++) begin
            run_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       32'($urandom_range(0, 255)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
